// File: rtl/rom_pkg.sv
// Shared types and constants for the iNES ROM loader: FSM states, header magic,
// error encodings and default NROM image sizes.
package rom_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PRG,
    S_CHR,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] INES_MAGIC0 = 8'h4E;
  localparam logic [7:0] INES_MAGIC1 = 8'h45;
  localparam logic [7:0] INES_MAGIC2 = 8'h53;
  localparam logic [7:0] INES_MAGIC3 = 8'h1A;

  // Only one 16k PRG bank and one 8k CHR bank are supported
  localparam logic [7:0] INES_PRG_UNITS = 8'h01;
  localparam logic [7:0] INES_CHR_UNITS = 8'h01;
  localparam int         INES_TRAINER_BIT = 2;

  localparam int HDR_LEN = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TRAINER = 2'd3;

  localparam int PRG_BYTES_DEF = 16384;
  localparam int CHR_BYTES_DEF = 8192;

endpackage

// File: rtl/ines_header_check.sv
// Combinational check of one iNES header byte against its position in the header.
// Latency 0; no flow control, the caller decides when the result is used.
module ines_header_check
  import rom_pkg::*;
(
  input  logic [3:0] i_idx,
  input  logic [7:0] i_data,
  output logic       o_pass,
  output logic [1:0] o_err_code
);

  always_comb begin
    o_pass     = 1'b1;
    o_err_code = ERR_NONE;
    case (i_idx)
      4'd0: if (i_data != INES_MAGIC0) begin o_pass = 1'b0; o_err_code = ERR_MAGIC; end
      4'd1: if (i_data != INES_MAGIC1) begin o_pass = 1'b0; o_err_code = ERR_MAGIC; end
      4'd2: if (i_data != INES_MAGIC2) begin o_pass = 1'b0; o_err_code = ERR_MAGIC; end
      4'd3: if (i_data != INES_MAGIC3) begin o_pass = 1'b0; o_err_code = ERR_MAGIC; end
      4'd4: if (i_data != INES_PRG_UNITS) begin o_pass = 1'b0; o_err_code = ERR_SIZE; end
      4'd5: if (i_data != INES_CHR_UNITS) begin o_pass = 1'b0; o_err_code = ERR_SIZE; end
      4'd6: if (i_data[INES_TRAINER_BIT]) begin o_pass = 1'b0; o_err_code = ERR_TRAINER; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rom_loader.sv
// Streams an iNES image into PRG/CHR ROM write ports; writes appear one cycle after
// byte acceptance, and in_ready drops outside HEADER/PRG/CHR so the source stalls.
module rom_loader
  import rom_pkg::*;
#(
  parameter int PRG_BYTES = PRG_BYTES_DEF,
  parameter int CHR_BYTES = CHR_BYTES_DEF
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prg_we,
  output logic [13:0] prg_addr,
  output logic [7:0]  prg_wd,
  output logic        chr_we,
  output logic [12:0] chr_addr,
  output logic [7:0]  chr_wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        cpu_hold
);

  localparam logic [13:0] HDR_LAST = 14'(HDR_LEN - 1);
  localparam logic [13:0] PRG_LAST = 14'(PRG_BYTES - 1);
  localparam logic [13:0] CHR_LAST = 14'(CHR_BYTES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_cnt;
  logic [13:0] w_cnt_nxt;
  logic [1:0]  r_err_code;
  logic [1:0]  w_err_code_nxt;
  logic        w_accept;
  logic        w_hdr_pass;
  logic [1:0]  w_hdr_err_code;
  logic        r_prg_we;
  logic [13:0] r_prg_addr;
  logic [7:0]  r_prg_wd;
  logic        r_chr_we;
  logic [12:0] r_chr_addr;
  logic [7:0]  r_chr_wd;

  ines_header_check u_hdr_check (
    .i_idx      (r_cnt[3:0]),
    .i_data     (in_data),
    .o_pass     (w_hdr_pass),
    .o_err_code (w_hdr_err_code)
  );

  assign in_ready = (r_state == S_HEADER) || (r_state == S_PRG) || (r_state == S_CHR);
  assign busy     = in_ready;
  assign w_accept = in_valid && in_ready;
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERROR);
  assign err_code = r_err_code;
  assign cpu_hold = !done;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt    = S_HEADER;
          w_cnt_nxt      = '0;
          w_err_code_nxt = ERR_NONE;
        end
      end
      S_HEADER: begin
        if (w_accept) begin
          if (!w_hdr_pass) begin
            w_state_nxt    = S_ERROR;
            w_err_code_nxt = w_hdr_err_code;
          end else if (r_cnt == HDR_LAST) begin
            w_state_nxt = S_PRG;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 14'd1;
          end
        end
      end
      S_PRG: begin
        if (w_accept) begin
          if (r_cnt == PRG_LAST) begin
            w_state_nxt = S_CHR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 14'd1;
          end
        end
      end
      S_CHR: begin
        if (w_accept) begin
          if (r_cnt == CHR_LAST) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 14'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  // Write strobes are single-cycle; address/data hold their last value between writes
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      r_prg_we   <= 1'b0;
      r_prg_addr <= '0;
      r_prg_wd   <= '0;
      r_chr_we   <= 1'b0;
      r_chr_addr <= '0;
      r_chr_wd   <= '0;
    end else begin
      r_prg_we <= w_accept && (r_state == S_PRG);
      r_chr_we <= w_accept && (r_state == S_CHR);
      if (w_accept && (r_state == S_PRG)) begin
        r_prg_addr <= r_cnt;
        r_prg_wd   <= in_data;
      end
      if (w_accept && (r_state == S_CHR)) begin
        r_chr_addr <= r_cnt[12:0];
        r_chr_wd   <= in_data;
      end
    end
  end

  assign prg_we   = r_prg_we;
  assign prg_addr = r_prg_addr;
  assign prg_wd   = r_prg_wd;
  assign chr_we   = r_chr_we;
  assign chr_addr = r_chr_addr;
  assign chr_wd   = r_chr_wd;

endmodule
